// File: rtl/vga_trace_pkg.sv
// vga_trace_pkg: shared timing constants, buffer entry type and row helper for the VGA trace plotter
package vga_trace_pkg;
    localparam int H_VIS = 640;
    localparam int H_FP = 16;
    localparam int H_SYNC = 96;
    localparam int H_BP = 48;
    localparam int V_VIS = 480;
    localparam int V_FP = 10;
    localparam int V_SYNC = 2;
    localparam int V_BP = 33;
    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int H_SYNC_START = H_VIS + H_FP;
    localparam int H_SYNC_END = H_SYNC_START + H_SYNC - 1;
    localparam int V_SYNC_START = V_VIS + V_FP;
    localparam int V_SYNC_END = V_SYNC_START + V_SYNC - 1;
    localparam int COLS = 160;
    localparam int ROWS = 240;
    localparam int GRID_COL_STEP = 20;
    localparam int GRID_ROW_STEP = 30;
    localparam logic [11:0] GRID_COLOR = 12'h444;
    typedef struct packed {
        logic [7:0] y;
        logic [11:0] color;
    } entry_t;
    // Larger samples map to smaller row numbers (higher on screen); samples above the raster clip to the top row.
    function automatic logic [7:0] target_row(input logic [7:0] y);
        return 8'(ROWS - 1) - ((y > 8'(ROWS - 1)) ? 8'(ROWS - 1) : y);
    endfunction
endpackage

// File: rtl/vga_trace_plotter_if.sv
// vga_trace_plotter_if: trace-point write bus plus VGA pin bundle
//   wr_en/wr_x/wr_y/wr_color : point stream from the sample plotter
//   hsync/vsync/de/rgb       : VGA outputs towards the DAC
//   master = point source / pin sink, slave = the plotter
interface vga_trace_plotter_if;
    logic wr_en;
    logic [7:0] wr_x;
    logic [7:0] wr_y;
    logic [11:0] wr_color;
    logic hsync;
    logic vsync;
    logic de;
    logic [11:0] rgb;
    modport master (output wr_en, wr_x, wr_y, wr_color, input hsync, vsync, de, rgb);
    modport slave (input wr_en, wr_x, wr_y, wr_color, output hsync, vsync, de, rgb);
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: free-running VGA pixel/line counters with combinational sync and display enable
//   clk, rst            : pixel clock, synchronous active-high reset
//   hcount_o, vcount_o  : current pixel and line counters
//   hsync_o, vsync_o    : active-low syncs decoded from the counters
//   de_o                : high inside the visible area
module vga_timing_gen #(
    parameter int H_VIS = vga_trace_pkg::H_VIS,
    parameter int H_FP = vga_trace_pkg::H_FP,
    parameter int H_SYNC = vga_trace_pkg::H_SYNC,
    parameter int H_BP = vga_trace_pkg::H_BP,
    parameter int V_VIS = vga_trace_pkg::V_VIS,
    parameter int V_FP = vga_trace_pkg::V_FP,
    parameter int V_SYNC = vga_trace_pkg::V_SYNC,
    parameter int V_BP = vga_trace_pkg::V_BP
) (
    input  logic       clk,
    input  logic       rst,
    output logic [9:0] hcount_o,
    output logic [9:0] vcount_o,
    output logic       hsync_o,
    output logic       vsync_o,
    output logic       de_o
);
    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_VIS + H_FP;
    localparam int HS_END = HS_START + H_SYNC - 1;
    localparam int VS_START = V_VIS + V_FP;
    localparam int VS_END = VS_START + V_SYNC - 1;
    logic [9:0] hcount_q, hcount_d, vcount_q, vcount_d;
    logic h_last;
    always_comb begin
        h_last = hcount_q == 10'(H_TOTAL - 1);
        hcount_d = h_last ? '0 : hcount_q + 10'd1;
        vcount_d = !h_last ? vcount_q : (vcount_q == 10'(V_TOTAL - 1)) ? '0 : vcount_q + 10'd1;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            hcount_q <= '0;
            vcount_q <= '0;
        end else begin
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
        end
    end
    assign hcount_o = hcount_q;
    assign vcount_o = vcount_q;
    assign hsync_o = !(hcount_q >= 10'(HS_START) && hcount_q <= 10'(HS_END));
    assign vsync_o = !(vcount_q >= 10'(VS_START) && vcount_q <= 10'(VS_END));
    assign de_o = (hcount_q < 10'(H_VIS)) && (vcount_q < 10'(V_VIS));
endmodule

// File: rtl/vga_trace_plotter.sv
// vga_trace_plotter: stores the latest point per column and draws a continuous trace on 640x480@60 VGA
//   clk, rst : 25 MHz pixel clock, synchronous active-high reset
//   bus      : slave side of vga_trace_plotter_if (point writes in, hsync/vsync/de/rgb out)
//   Pins lag the counters by exactly 2 clocks (counters -> RAM read -> output registers).
//   Optional VGA_TRACE_GRID_EN draws a grey 8x8 grid behind the trace.
module vga_trace_plotter #(
    parameter int H_VIS = vga_trace_pkg::H_VIS,
    parameter int H_FP = vga_trace_pkg::H_FP,
    parameter int H_SYNC = vga_trace_pkg::H_SYNC,
    parameter int H_BP = vga_trace_pkg::H_BP,
    parameter int V_VIS = vga_trace_pkg::V_VIS,
    parameter int V_FP = vga_trace_pkg::V_FP,
    parameter int V_SYNC = vga_trace_pkg::V_SYNC,
    parameter int V_BP = vga_trace_pkg::V_BP
) (
    input logic clk,
    input logic rst,
    vga_trace_plotter_if.slave bus
);
    import vga_trace_pkg::*;
    logic [9:0] hcount, vcount;
    logic hs0, vs0, de0;
    vga_timing_gen #(
        .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing (
        .clk(clk),
        .rst(rst),
        .hcount_o(hcount),
        .vcount_o(vcount),
        .hsync_o(hs0),
        .vsync_o(vs0),
        .de_o(de0)
    );
    entry_t ram_q [COLS];
    entry_t rd_q;
    logic [COLS-1:0] valid_q;
    logic [7:0] col, rd_addr;
    logic wr_hit;
    assign col = 8'(hcount >> 2);
    // Blanking columns (160..199) fold onto entry 0; their pixels are masked by de anyway.
    assign rd_addr = (col < 8'(COLS)) ? col : '0;
    assign wr_hit = bus.wr_en && (bus.wr_x < 8'(COLS));
    // Buffer contents are deliberately not reset; validity is tracked separately.
    always_ff @(posedge clk) begin
        if (wr_hit) ram_q[bus.wr_x] <= '{y: bus.wr_y, color: bus.wr_color};
        rd_q <= ram_q[rd_addr];
    end
    always_ff @(posedge clk) begin
        if (rst) valid_q <= '0;
        else if (wr_hit) valid_q[bus.wr_x] <= 1'b1;
    end
    logic v1_q, hs1_q, vs1_q, de1_q;
    logic [7:0] col1_q;
    logic [8:0] r1_q;
    logic [7:0] last_col_q, last_t_q, prev_t_q;
    logic last_v_q, prev_v_q;
    logic hs2_q, vs2_q, de2_q;
    logic [11:0] rgb_q, rgb_d, bg;
    logic [7:0] t1, pt, eff, lo, hi;
    logic new_col, pv, lit;
    // The previous column's row is captured on the first pixel of each new column and held
    // for the rest of it, so the vertical segment joins this column to its left neighbour.
    always_comb begin
        t1 = target_row(rd_q.y);
        new_col = col1_q != last_col_q;
        pt = new_col ? last_t_q : prev_t_q;
        pv = new_col ? last_v_q : prev_v_q;
        eff = (col1_q == '0 || !pv) ? t1 : pt;
        lo = (eff < t1) ? eff : t1;
        hi = (eff < t1) ? t1 : eff;
        lit = v1_q && (r1_q >= {1'b0, lo}) && (r1_q <= {1'b0, hi});
`ifdef VGA_TRACE_GRID_EN
        bg = (col1_q % 8'(GRID_COL_STEP) == '0 || r1_q % 9'(GRID_ROW_STEP) == '0) ? GRID_COLOR : '0;
`else
        bg = '0;
`endif
        rgb_d = !de1_q ? '0 : lit ? rd_q.color : bg;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q <= 1'b0;
            col1_q <= '0;
            r1_q <= '0;
            hs1_q <= 1'b1;
            vs1_q <= 1'b1;
            de1_q <= 1'b0;
            last_col_q <= '0;
            last_t_q <= '0;
            last_v_q <= 1'b0;
            prev_t_q <= '0;
            prev_v_q <= 1'b0;
            hs2_q <= 1'b1;
            vs2_q <= 1'b1;
            de2_q <= 1'b0;
            rgb_q <= '0;
        end else begin
            v1_q <= valid_q[rd_addr];
            col1_q <= col;
            r1_q <= 9'(vcount >> 1);
            hs1_q <= hs0;
            vs1_q <= vs0;
            de1_q <= de0;
            last_col_q <= col1_q;
            last_t_q <= t1;
            last_v_q <= v1_q;
            prev_t_q <= pt;
            prev_v_q <= pv;
            hs2_q <= hs1_q;
            vs2_q <= vs1_q;
            de2_q <= de1_q;
            rgb_q <= rgb_d;
        end
    end
    assign bus.hsync = hs2_q;
    assign bus.vsync = vs2_q;
    assign bus.de = de2_q;
    assign bus.rgb = rgb_q;
endmodule

// File: doc/vga_trace_plotter.md
Name: vga_trace_plotter

Overview:
- Receiving end of the trace-point stream from the sample plotter. The upstream block supplies one point per clock: an x column (0..159), an 8-bit y sample and a 12-bit colour.
- This block stores the latest y and colour per column in a 160-entry column buffer.
- It generates 640x480@60 VGA timing and draws the trace. Each column is 4 pixels wide and each row is 2 lines tall, giving a 160x240 logical raster.
- Sits between the plotter and the DAC/connector pins. Clock is the 25 MHz pixel clock.

Parameters:
- H_VIS, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_VIS, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch
- COLS, 160, logical columns (H_VIS/4)
- ROWS, 240, logical rows (V_VIS/2)

Ports:
- clk  in  1  pixel clock, 25 MHz
- rst  in  1  synchronous active-high reset
- wr_en  in  1  point valid this cycle
- wr_x  in  8  column index
- wr_y  in  8  sample value (0 = bottom)
- wr_color  in  12  RGB 4:4:4 for this point
- hsync  out  1  active-low horizontal sync
- vsync  out  1  active-low vertical sync
- de  out  1  display enable
- rgb  out  12  pixel colour

Behaviour:
- Reset values:
  - hcount = 0, vcount = 0.
  - hsync = 1, vsync = 1, de = 0, rgb = 0.
  - All 160 column-valid bits cleared. Buffer RAM contents are not reset.
- Reset mid-frame: counters restart at (0,0) on the next cycle; outputs take their reset values.
- Counters:
  - hcount runs 0..799 and wraps to 0.
  - vcount increments when hcount = 799 and runs 0..524, wrapping to 0.
- Sync and enable:
  - hsync is low for hcount 656..751.
  - vsync is low for vcount 490..491.
  - de = (hcount < 640) and (vcount < 480).
- Write side:
  - When wr_en = 1 and wr_x < 160: write {wr_y, wr_color} to entry wr_x and set valid[wr_x].
  - wr_x >= 160 is ignored.
  - Writes are accepted every cycle with no backpressure.
- Read side:
  - Column col = hcount>>2, read synchronously with 1-cycle latency.
  - Same-address read and write in one cycle returns the old data (read-before-write).
- Trace row:
  - Clipped sample yc = min(y, 239).
  - Logical row r = vcount>>1.
  - Target row t = 239 - yc, so larger samples appear higher on screen.
- Continuity:
  - prev_t holds the previous column's t. It is latched when the column index changes.
  - At col 0, or when the previous column is invalid, prev_t = t.
  - Pixel is lit when r lies between min(prev_t, t) and max(prev_t, t) inclusive, and valid[col] = 1.
- Pipeline:
  - Stage 0: counters.
  - Stage 1: RAM read, plus sync and de delayed by one cycle.
  - Stage 2: registered outputs.
  - Fixed latency of 2 clocks from counter value to pins. hsync, vsync, de and rgb are all delayed equally.
- rgb = stored colour when lit and de = 1, otherwise 0. rgb is forced to 0 whenever de = 0.

Optional Feature:
- VGA_TRACE_GRID_EN
- Defined: unlit visible pixels where (col % 20 == 0) or (r % 30 == 0) output 12'h444, drawing an 8x8 grid. The trace overrides the grid.
- Undefined: grid logic is absent and unlit pixels are 0.

Decomposition:
- Package vga_trace_pkg holds:
  - the timing constants;
  - derived totals (H_TOTAL 800, V_TOTAL 525);
  - sync start/end values;
  - the GRID_COLOR constant;
  - a typedef for the 20-bit buffer entry {y[7:0], color[11:0]}.
- Sub-module vga_timing_gen: hcount, vcount, hsync, vsync, de. Reusable by other display blocks.
- The column RAM is inferred inline.

Test Plan:
- Reset, then free-run 2 frames -> hsync period 800 clocks with low width 96; vsync period 420000 clocks with low width 1600; de high for 640 clocks per visible line; rgb = 0 throughout (no valid columns).
- Write x=10, y=100, color=12'hF00; neighbours x=9 and x=11 not written -> logical row 139 (vcount 278..279, pin hcount 40..43 after 2-clock latency) outputs F00; all other rows of col 10 output 0.
- Write x=0 y=239 and x=1 y=200, colour 0F0 -> col 0 lit only at row 0; col 1 lit rows 0..39.
- Write x=5 y=255 -> clipped, lit at row 0 only. Write x=200 -> no change anywhere.
- Write to col 20 during the cycle col 20 is being read -> current line shows old data; the next line shows new data.
- With VGA_TRACE_GRID_EN defined and no writes -> pixels at col 0/20/40... and rows 0/30/60... output 12'h444; a trace point on a grid line shows its own colour.
